// File: rtl/tl_tx_scheduler.sv
// tl_tx_scheduler: TL Tx scheduler arbitrating P/NP/CPL FIFOs onto the DLL beat stream.
// Optional build macro TL_TX_SCHED_CPL_PRIO_EN gives eligible completions absolute priority.
module tl_tx_scheduler #(
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int MAX_PAYLOAD_DW  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       link_active_i,
  input  logic [RETRY_DEPTH_LG2+2:0] retry_left_i,
  input  logic [11:0]                ca_ph_i,
  input  logic [11:0]                ca_pd_i,
  input  logic [11:0]                ca_nh_i,
  input  logic [11:0]                ca_ch_i,
  input  logic [11:0]                ca_cd_i,
  input  logic                       p_hdr_empty_i,
  input  logic [127:0]               p_hdr_rdata_i,
  output logic                       p_hdr_rden_o,
  input  logic                       p_data_empty_i,
  input  logic [255:0]               p_data_rdata_i,
  output logic                       p_data_rden_o,
  input  logic                       np_hdr_empty_i,
  input  logic [127:0]               np_hdr_rdata_i,
  output logic                       np_hdr_rden_o,
  input  logic                       cpl_hdr_empty_i,
  input  logic [95:0]                cpl_hdr_rdata_i,
  output logic                       cpl_hdr_rden_o,
  input  logic                       cpl_data_empty_i,
  input  logic [255:0]               cpl_data_rdata_i,
  output logic                       cpl_data_rden_o,
  output logic [255:0]               tlp_o,
  output logic [2:0]                 req_o,
  output logic                       ph_use_o,
  output logic                       nh_use_o,
  output logic                       ch_use_o,
  output logic [8:0]                 pd_use_o,
  output logic [8:0]                 cd_use_o,
  output logic                       p_sent_o,
  output logic                       cpl_sent_o
);
  localparam int BW = $clog2(MAX_PAYLOAD_DW / 8) + 1;
  typedef enum logic {IDLE, DATA} state_t;
  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic           cpl_q, cpl_d;
  logic [BW-1:0]  cnt_q, cnt_d;
  logic [255:0]   tlp_q, tlp_d;
  logic [2:0]     req_q, req_d;
  logic           ph_q, ph_d, nh_q, nh_d, ch_q, ch_d, ps_q, ps_d, cs_q, cs_d;
  logic [8:0]     pd_q, pd_d, cd_q, cd_d;
  logic [10:0]    p_len, c_len, p_dc, c_dc;
  logic [BW-1:0]  p_bt, c_bt;
  logic           p_hd, c_hd, any, d_empty;
  logic [2:0]     e;
  logic [1:0]     n1, n2, win;

  // A zero length field encodes the maximum 1024 DW payload.
  assign p_len = p_hdr_rdata_i[9:0] == 10'd0 ? 11'd1024 : {1'b0, p_hdr_rdata_i[9:0]};
  assign c_len = cpl_hdr_rdata_i[9:0] == 10'd0 ? 11'd1024 : {1'b0, cpl_hdr_rdata_i[9:0]};
  assign p_hd  = p_hdr_rdata_i[30];
  assign c_hd  = cpl_hdr_rdata_i[30];
  assign p_dc  = (p_len + 11'd3) >> 2;
  assign c_dc  = (c_len + 11'd3) >> 2;
  assign p_bt  = BW'((p_len + 11'd7) >> 3);
  assign c_bt  = BW'((c_len + 11'd7) >> 3);

  assign e[0] = link_active_i && !p_hdr_empty_i && ca_ph_i != 12'd0 &&
                (!p_hd || (ca_pd_i >= {1'b0, p_dc} && !p_data_empty_i)) &&
                int'(retry_left_i) >= (p_hd ? int'(p_len) : 0) + 4;
  assign e[1] = link_active_i && !np_hdr_empty_i && ca_nh_i != 12'd0 &&
                int'(retry_left_i) >= 4;
  assign e[2] = link_active_i && !cpl_hdr_empty_i && ca_ch_i != 12'd0 &&
                (!c_hd || (ca_cd_i >= {1'b0, c_dc} && !cpl_data_empty_i)) &&
                int'(retry_left_i) >= (c_hd ? int'(c_len) : 0) + 3;
  assign any = |e;

  assign n1 = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
  assign n2 = n1 == 2'd2 ? 2'd0 : n1 + 2'd1;
`ifdef TL_TX_SCHED_CPL_PRIO_EN
  // Pointer only ever holds P or NP here; completions bypass it entirely.
  assign win = e[2] ? 2'd2 : e[ptr_q] ? ptr_q : {1'b0, ~ptr_q[0]};
`else
  assign win = e[ptr_q] ? ptr_q : e[n1] ? n1 : n2;
`endif
  assign d_empty = cpl_q ? cpl_data_empty_i : p_data_empty_i;

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cpl_d = cpl_q;
    cnt_d = cnt_q;
    tlp_d = '0;
    req_d = 3'd0;
    ph_d = 1'b0;
    nh_d = 1'b0;
    ch_d = 1'b0;
    pd_d = 9'd0;
    cd_d = 9'd0;
    ps_d = 1'b0;
    cs_d = 1'b0;
    p_hdr_rden_o = 1'b0;
    np_hdr_rden_o = 1'b0;
    cpl_hdr_rden_o = 1'b0;
    p_data_rden_o = 1'b0;
    cpl_data_rden_o = 1'b0;
    if (state_q == IDLE && any && !rst) begin
`ifdef TL_TX_SCHED_CPL_PRIO_EN
      ptr_d = win == 2'd2 ? ptr_q : {1'b0, ~win[0]};
`else
      ptr_d = win == 2'd2 ? 2'd0 : win + 2'd1;
`endif
      if (win == 2'd0) begin
        p_hdr_rden_o = 1'b1;
        tlp_d = {128'd0, p_hdr_rdata_i};
        req_d = 3'd1;
        ph_d = 1'b1;
        pd_d = p_hd ? p_dc[8:0] : 9'd0;
        state_d = p_hd ? DATA : IDLE;
        cnt_d = p_bt;
        cpl_d = 1'b0;
      end else if (win == 2'd1) begin
        np_hdr_rden_o = 1'b1;
        tlp_d = {128'd0, np_hdr_rdata_i};
        req_d = 3'd3;
        nh_d = 1'b1;
      end else begin
        cpl_hdr_rden_o = 1'b1;
        tlp_d = {160'd0, cpl_hdr_rdata_i};
        req_d = 3'd5;
        ch_d = 1'b1;
        cd_d = c_hd ? c_dc[8:0] : 9'd0;
        state_d = c_hd ? DATA : IDLE;
        cnt_d = c_bt;
        cpl_d = 1'b1;
      end
    end else if (state_q == DATA && !d_empty && !rst) begin
      p_data_rden_o = !cpl_q;
      cpl_data_rden_o = cpl_q;
      tlp_d = cpl_q ? cpl_data_rdata_i : p_data_rdata_i;
      req_d = cpl_q ? 3'd6 : 3'd2;
      cnt_d = cnt_q - BW'(1);
      ps_d = cnt_q == BW'(1) && !cpl_q;
      cs_d = cnt_q == BW'(1) && cpl_q;
      state_d = cnt_q == BW'(1) ? IDLE : DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= 2'd0;
      cpl_q <= 1'b0;
      cnt_q <= '0;
      tlp_q <= '0;
      req_q <= 3'd0;
      ph_q <= 1'b0;
      nh_q <= 1'b0;
      ch_q <= 1'b0;
      pd_q <= 9'd0;
      cd_q <= 9'd0;
      ps_q <= 1'b0;
      cs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cpl_q <= cpl_d;
      cnt_q <= cnt_d;
      tlp_q <= tlp_d;
      req_q <= req_d;
      ph_q <= ph_d;
      nh_q <= nh_d;
      ch_q <= ch_d;
      pd_q <= pd_d;
      cd_q <= cd_d;
      ps_q <= ps_d;
      cs_q <= cs_d;
    end
  end

  assign tlp_o = tlp_q;
  assign req_o = req_q;
  assign ph_use_o = ph_q;
  assign nh_use_o = nh_q;
  assign ch_use_o = ch_q;
  assign pd_use_o = pd_q;
  assign cd_use_o = cd_q;
  assign p_sent_o = ps_q;
  assign cpl_sent_o = cs_q;
endmodule

// File: tb/tb_tl_tx_scheduler.sv
// tb_tl_tx_scheduler: directed bench for tl_tx_scheduler with show-ahead FIFO models.
module tb_tl_tx_scheduler;
  logic clk, rst, link;
  logic [10:0] retry;
  logic [11:0] ca_ph, ca_pd, ca_nh, ca_ch, ca_cd;
  logic p_hdr_empty, p_data_empty, np_hdr_empty, cpl_hdr_empty, cpl_data_empty;
  logic [127:0] p_hdr_rdata, np_hdr_rdata;
  logic [95:0] cpl_hdr_rdata;
  logic [255:0] p_data_rdata, cpl_data_rdata, tlp;
  logic p_hdr_rden, p_data_rden, np_hdr_rden, cpl_hdr_rden, cpl_data_rden;
  logic [2:0] req;
  logic ph_use, nh_use, ch_use, p_sent, cpl_sent;
  logic [8:0] pd_use, cd_use;
  logic [127:0] qph[$], qnh[$];
  logic [95:0] qch[$];
  logic [255:0] qpd[$], qcd[$];
  logic rph, rpd, rnh, rch, rcd;
  int checks = 0, errors = 0, nh_rd_cnt = 0, ph_rd_cnt = 0;
  logic [127:0] h, h2;
  logic [2:0] ord [3];

  tl_tx_scheduler dut (
    .clk(clk), .rst(rst), .link_active_i(link), .retry_left_i(retry),
    .ca_ph_i(ca_ph), .ca_pd_i(ca_pd), .ca_nh_i(ca_nh), .ca_ch_i(ca_ch), .ca_cd_i(ca_cd),
    .p_hdr_empty_i(p_hdr_empty), .p_hdr_rdata_i(p_hdr_rdata), .p_hdr_rden_o(p_hdr_rden),
    .p_data_empty_i(p_data_empty), .p_data_rdata_i(p_data_rdata), .p_data_rden_o(p_data_rden),
    .np_hdr_empty_i(np_hdr_empty), .np_hdr_rdata_i(np_hdr_rdata), .np_hdr_rden_o(np_hdr_rden),
    .cpl_hdr_empty_i(cpl_hdr_empty), .cpl_hdr_rdata_i(cpl_hdr_rdata), .cpl_hdr_rden_o(cpl_hdr_rden),
    .cpl_data_empty_i(cpl_data_empty), .cpl_data_rdata_i(cpl_data_rdata), .cpl_data_rden_o(cpl_data_rden),
    .tlp_o(tlp), .req_o(req), .ph_use_o(ph_use), .nh_use_o(nh_use), .ch_use_o(ch_use),
    .pd_use_o(pd_use), .cd_use_o(cd_use), .p_sent_o(p_sent), .cpl_sent_o(cpl_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] tag, input logic hd, input logic [9:0] len);
    logic [127:0] r;
    r = '0;
    r[9:0] = len;
    r[30] = hd;
    r[47:40] = tag;
    r[127:120] = tag;
    return r;
  endfunction

  function automatic logic [255:0] dat(input logic [31:0] n);
    return {8{n}};
  endfunction

  task automatic refresh();
    p_hdr_empty = qph.size() == 0;
    p_hdr_rdata = qph.size() != 0 ? qph[0] : '0;
    np_hdr_empty = qnh.size() == 0;
    np_hdr_rdata = qnh.size() != 0 ? qnh[0] : '0;
    cpl_hdr_empty = qch.size() == 0;
    cpl_hdr_rdata = qch.size() != 0 ? qch[0] : '0;
    p_data_empty = qpd.size() == 0;
    p_data_rdata = qpd.size() != 0 ? qpd[0] : '0;
    cpl_data_empty = qcd.size() == 0;
    cpl_data_rdata = qcd.size() != 0 ? qcd[0] : '0;
  endtask

  task automatic cyc();
    logic [255:0] d;
    #1;
    rph = p_hdr_rden; rpd = p_data_rden; rnh = np_hdr_rden; rch = cpl_hdr_rden; rcd = cpl_data_rden;
    @(posedge clk);
    #1;
    if (rph) begin d[127:0] = qph.pop_front(); ph_rd_cnt++; end
    if (rnh) begin d[127:0] = qnh.pop_front(); nh_rd_cnt++; end
    if (rch) d[95:0] = qch.pop_front();
    if (rpd) d = qpd.pop_front();
    if (rcd) d = qcd.pop_front();
    refresh();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qph.delete(); qnh.delete(); qch.delete(); qpd.delete(); qcd.delete();
    refresh();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ph_rd_cnt = 0;
    nh_rd_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; link = 1'b1; retry = 11'd200;
    ca_ph = 12'd100; ca_pd = 12'd100; ca_nh = 12'd100; ca_ch = 12'd100; ca_cd = 12'd100;
    qph.push_back(mk(8'h01, 1'b0, 10'd1));
    refresh();
    #1;
    chk("rst_outs", {tlp, 7'd0, req, ph_use, nh_use, ch_use, pd_use, cd_use, p_sent, cpl_sent}, '0);
    chk("rst_rden", {p_hdr_rden, p_data_rden, np_hdr_rden, cpl_hdr_rden, cpl_data_rden}, '0);
    do_reset();

    h = mk(8'h11, 1'b1, 10'd16);
    qph.push_back(h); qpd.push_back(dat(32'hD0)); qpd.push_back(dat(32'hD1));
    refresh();
    cyc();
    chk("t1_req_hdr", req, 3'd1);
    chk("t1_ph_use", ph_use, 1);
    chk("t1_pd_use", pd_use, 9'd4);
    chk("t1_tlp_hdr", tlp, {128'd0, h});
    chk("t1_hdr_rden", rph, 1);
    cyc();
    chk("t1_req_d0", req, 3'd2);
    chk("t1_tlp_d0", tlp, dat(32'hD0));
    chk("t1_rden_d0", rpd, 1);
    chk("t1_sent_d0", p_sent, 0);
    cyc();
    chk("t1_req_d1", req, 3'd2);
    chk("t1_tlp_d1", tlp, dat(32'hD1));
    chk("t1_sent_d1", p_sent, 1);
    cyc();
    chk("t1_idle", {req, p_sent}, 4'd0);

    do_reset();
`ifdef TL_TX_SCHED_CPL_PRIO_EN
    ord = '{3'd5, 3'd1, 3'd3};
`else
    ord = '{3'd1, 3'd3, 3'd5};
`endif
    h = mk(8'h33, 1'b0, 10'd0);
    qph.push_back(mk(8'h21, 1'b0, 10'd1));
    qnh.push_back(mk(8'h22, 1'b0, 10'd1));
    qch.push_back(h[95:0]);
    refresh();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t2_order%0d", i), req, ord[i]);
      if (ord[i] == 3'd5) chk("t2_cpl_tlp", tlp, {160'd0, h[95:0]});
      if (ord[i] == 3'd3) chk("t2_nh_use", nh_use, 1);
    end
    qnh.push_back(mk(8'h24, 1'b0, 10'd1));
    qph.push_back(mk(8'h23, 1'b0, 10'd1));
    refresh();
    cyc();
    chk("t2_ptr_p", req, 3'd1);
    cyc();
    chk("t2_np_after", req, 3'd3);

    do_reset();
    ca_nh = 12'd0;
    qnh.push_back(mk(8'h31, 1'b0, 10'd1));
    qph.push_back(mk(8'h32, 1'b0, 10'd1));
    refresh();
    cyc();
    chk("t3_p_first", req, 3'd1);
    repeat (2) cyc();
    chk("t3_np_held", req, 3'd0);
    chk("t3_np_rden_cnt", nh_rd_cnt, 0);
    ca_nh = 12'd1;
    cyc();
    chk("t3_np_grant", {req, nh_use}, {3'd3, 1'b1});
    ca_nh = 12'd100;

    do_reset();
    link = 1'b0;
    h = mk(8'h41, 1'b1, 10'd8);
    qph.push_back(h); qpd.push_back(dat(32'hE0));
    refresh();
    cyc();
    chk("t4_link_down", req, 3'd0);
    link = 1'b1;
    retry = 11'd11;
    cyc();
    chk("t4_retry11", req, 3'd0);
    chk("t4_no_rden", ph_rd_cnt, 0);
    retry = 11'd12;
    cyc();
    chk("t4_retry12", {req, pd_use}, {3'd1, 9'd2});
    cyc();
    chk("t4_data", {req, p_sent}, {3'd2, 1'b1});
    retry = 11'd200;

    do_reset();
    qph.push_back(mk(8'h51, 1'b1, 10'd24)); qpd.push_back(dat(32'hA0));
    refresh();
    cyc();
    chk("t5_hdr", {req, pd_use}, {3'd1, 9'd6});
    cyc();
    chk("t5_beat0", tlp, dat(32'hA0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t5_bubble%0d", i), {req, rpd, p_sent}, 5'd0);
    end
    qpd.push_back(dat(32'hA1)); qpd.push_back(dat(32'hA2));
    refresh();
    cyc();
    chk("t5_beat1", {req, p_sent}, {3'd2, 1'b0});
    cyc();
    chk("t5_beat2", {tlp, req, p_sent}, {dat(32'hA2), 3'd2, 1'b1});

    do_reset();
    h = mk(8'h61, 1'b1, 10'd32);
    qph.push_back(h);
    for (int i = 0; i < 4; i++) qpd.push_back(dat(32'hB0 + i));
    refresh();
    cyc();
    cyc();
    chk("t6_beat0", req, 3'd2);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", {tlp, req, p_sent, ph_use, pd_use}, '0);
    chk("t6_rst_rden", p_data_rden, 0);
    do_reset();
    h2 = mk(8'h62, 1'b0, 10'd1);
    qnh.push_back(mk(8'h63, 1'b0, 10'd1));
    qph.push_back(h2);
    refresh();
    cyc();
    chk("t6_restart_p", {tlp, req}, {128'd0, h2, 3'd1});

    do_reset();
    h = mk(8'h71, 1'b1, 10'd8);
    qch.push_back(h[95:0]); qcd.push_back(dat(32'hC0));
    refresh();
    cyc();
    chk("t7_cpl_hdr", {req, ch_use, cd_use}, {3'd5, 1'b1, 9'd2});
    cyc();
    chk("t7_cpl_data", {tlp, req, cpl_sent}, {dat(32'hC0), 3'd6, 1'b1});
    cyc();
    chk("t7_idle", {req, cpl_sent}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
